// File: rtl/lut_layer_pipe.sv
// Pipelined layer of LUT neurons with a fixed input connectivity map and
// run-time writable truth tables; one register stage, valid/ready on both sides.
module lut_layer_pipe #(
   parameter int IN_WIDTH = 12,
   parameter int NEURONS  = 2,
   parameter int FANIN    = 6,
   parameter int OUT_BITS = 1,
   parameter int IDX_W    = 4,
   parameter logic [NEURONS*FANIN*IDX_W-1:0] CONN = 48'hBA98_7654_3210,
   parameter int CFG_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_WIDTH-1:0]          in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NEURONS*OUT_BITS-1:0]  out_data,
   input  logic                         cfg_req,
   output logic                         cfg_ack,
   input  logic                         cfg_we,
   input  logic [CFG_W-1:0]             cfg_neuron,
   input  logic [FANIN-1:0]             cfg_entry,
   input  logic [OUT_BITS-1:0]          cfg_data
);

   localparam int DEPTH = 2**FANIN;
   localparam logic [CFG_W:0] NEURONS_L = NEURONS[CFG_W:0];

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CFG   = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic                         out_valid_q, out_valid_d;
   logic [NEURONS*OUT_BITS-1:0]  out_data_q, out_data_d;
   logic                         cfg_ack_q, cfg_ack_d;
   logic [OUT_BITS-1:0]          lut_q [NEURONS][DEPTH];
   logic [OUT_BITS-1:0]          lut_d [NEURONS][DEPTH];

   logic [FANIN-1:0]             addr_s [NEURONS];
   logic [NEURONS*OUT_BITS-1:0]  lookup_s;
   logic                         fire_s;
   logic                         wr_en_s;

   // Gather each neuron's address bits through the connectivity map and read its table.
   always_comb begin
      lookup_s = '0;
      for (int k = 0; k < NEURONS; k++) begin
         addr_s[k] = '0;
         for (int j = 0; j < FANIN; j++) begin
            addr_s[k][j] = in_data[CONN[(k*FANIN+j)*IDX_W +: IDX_W]];
         end
         lookup_s[k*OUT_BITS +: OUT_BITS] = lut_q[k][addr_s[k]];
      end
   end

   // Handshake, datapath next state and table writes.
   always_comb begin
      in_ready    = (state_q == ST_RUN) && !cfg_req && (!out_valid_q || out_ready) && !rst;
      fire_s      = in_valid && in_ready;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (fire_s) begin
         out_valid_d = 1'b1;
         out_data_d  = lookup_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      // Out-of-range neuron indices fall through without touching any table.
      wr_en_s = cfg_ack_q && cfg_we && ({1'b0, cfg_neuron} < NEURONS_L);
      lut_d   = lut_q;
      if (wr_en_s) begin
         lut_d[cfg_neuron][cfg_entry] = cfg_data;
      end else begin
         lut_d = lut_q;
      end
   end

   // Mode FSM: RUN streams, DRAIN empties the output stage, CFG opens the tables.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (cfg_req) begin
               state_d = out_valid_q ? ST_DRAIN : ST_CFG;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!cfg_req) begin
               state_d = ST_RUN;
            end else if (!out_valid_q) begin
               state_d = ST_CFG;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_CFG: begin
            if (!cfg_req) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_CFG;
            end
         end
         default: state_d = ST_RUN;
      endcase
      cfg_ack_d = (state_d == ST_CFG);
   end

   // State registers; reset also wipes every table entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         cfg_ack_q   <= 1'b0;
         for (int k = 0; k < NEURONS; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
               lut_q[k][e] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         cfg_ack_q   <= cfg_ack_d;
         lut_q       <= lut_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign cfg_ack   = cfg_ack_q;

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Randomized and directed bench for lut_layer_pipe against a behavioural
// model of the layer (table arrays, mode variable, output slot).
module tb_lut_layer_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_data;
   logic        cfg_req;
   logic        cfg_ack;
   logic        cfg_we;
   logic [0:0]  cfg_neuron;
   logic [5:0]  cfg_entry;
   logic [0:0]  cfg_data;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: mode 0=RUN 1=DRAIN 2=CFG, one output slot, two 64-entry tables.
   int         m_mode;
   bit         m_v;
   logic [1:0] m_d;
   bit         m_lut [2][64];

   lut_layer_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
      .cfg_entry(cfg_entry), .cfg_data(cfg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Identity map: neuron 0 reads in[5:0], neuron 1 reads in[11:6].
   function automatic logic [1:0] ref_lookup(input logic [11:0] x);
      logic [1:0] r;
      r[0] = m_lut[0][x[5:0]];
      r[1] = m_lut[1][x[11:6]];
      return r;
   endfunction

   task automatic tick();
      bit rdy;
      bit fire;
      int nmode;
      #1;
      rdy = !rst && (m_mode == 0) && !cfg_req && (!m_v || out_ready);
      check("in_ready", in_ready, rdy);
      @(posedge clk);
      if (rst) begin
         m_mode = 0; m_v = 0; m_d = 2'b00;
         for (int n = 0; n < 2; n++)
            for (int e = 0; e < 64; e++) m_lut[n][e] = 1'b0;
      end else begin
         fire  = in_valid && rdy;
         nmode = m_mode;
         if (m_mode == 2 && cfg_we) m_lut[cfg_neuron][cfg_entry] = cfg_data;
         if (m_mode == 0 && cfg_req) nmode = m_v ? 1 : 2;
         else if (m_mode == 1 && !cfg_req) nmode = 0;
         else if (m_mode == 1 && !m_v) nmode = 2;
         else if (m_mode == 2 && !cfg_req) nmode = 0;
         if (fire) begin
            m_d = ref_lookup(in_data);
            m_v = 1;
         end else if (out_ready) begin
            m_v = 0;
         end
         m_mode = nmode;
      end
      @(negedge clk);
      check("out_valid", out_valid, m_v);
      if (m_v) check("out_data", out_data, m_d);
      check("cfg_ack", cfg_ack, m_mode == 2);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 12'h000; out_ready = 1'b0;
      cfg_req = 1'b0; cfg_we = 1'b0; cfg_neuron = 1'b0; cfg_entry = 6'h00; cfg_data = 1'b0;
      m_mode = 0; m_v = 0; m_d = 2'b00;
      @(negedge clk);

      // T1 reset
      tick(); tick();
      check("t1_out_valid", out_valid, 1'b0);
      check("t1_out_data", out_data, 2'b00);
      check("t1_cfg_ack", cfg_ack, 1'b0);
      check("t1_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1 check("t1_ready_rel", in_ready, 1'b1);

      // T2 load two entries and infer
      cfg_req = 1'b1; tick();
      check("t2_ack", cfg_ack, 1'b1);
      cfg_we = 1'b1; cfg_neuron = 1'b0; cfg_entry = 6'h22; cfg_data = 1'b1; tick();
      cfg_neuron = 1'b1; cfg_entry = 6'h3F; tick();
      cfg_we = 1'b0; cfg_req = 1'b0; tick();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 12'hFE2; tick();
      check("t2_valid", out_valid, 1'b1);
      check("t2_fe2", out_data, 2'b11);
      in_data = 12'h000; tick();
      check("t2_000", out_data, 2'b00);
      in_valid = 1'b0; tick();

      // Random tables
      cfg_req = 1'b1; tick();
      for (int e = 0; e < 64; e++) begin
         for (int n = 0; n < 2; n++) begin
            cfg_we = 1'b1; cfg_neuron = n[0:0]; cfg_entry = e[5:0]; cfg_data = $urandom_range(0, 1);
            tick();
         end
      end
      cfg_we = 1'b0; cfg_req = 1'b0; tick();

      // T3 backpressure then full-rate streaming
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 12'($urandom); tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 12'($urandom); tick();
         check("t3_stream", out_valid, 1'b1);
      end

      // Random streaming with ignored writes
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = 12'($urandom);
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_neuron = 1'($urandom); cfg_entry = 6'($urandom); cfg_data = 1'($urandom);
         tick();
      end
      cfg_we = 1'b0;

      // T4 drain
      in_valid = 1'b1; out_ready = 1'b0; in_data = 12'($urandom); tick();
      in_valid = 1'b0; cfg_req = 1'b1; tick();
      check("t4_drain_ack", cfg_ack, 1'b0);
      in_valid = 1'b1; tick();
      in_valid = 1'b0; out_ready = 1'b1; tick();
      check("t4_valid_fell", out_valid, 1'b0);
      out_ready = 1'b0; tick();
      check("t4_ack", cfg_ack, 1'b1);

      // DRAIN abort: nothing written
      cfg_req = 1'b0; tick();
      in_valid = 1'b1; out_ready = 1'b0; in_data = 12'($urandom); tick();
      in_valid = 1'b0; cfg_req = 1'b1; tick();
      cfg_we = 1'b1; cfg_entry = 6'($urandom); cfg_data = 1'($urandom); tick();
      cfg_we = 1'b0; cfg_req = 1'b0; out_ready = 1'b1; tick();

      // T5 writes while not in CFG are ignored
      for (int i = 0; i < 20; i++) begin
         cfg_we = 1'b1; cfg_neuron = 1'($urandom); cfg_entry = 6'($urandom); cfg_data = 1'($urandom);
         in_valid = 1'b1; in_data = 12'($urandom); tick();
      end
      cfg_we = 1'b0; in_valid = 1'b0; tick();

      // T6 reset in CFG after one write
      cfg_req = 1'b1; tick();
      cfg_we = 1'b1; cfg_neuron = 1'b1; cfg_entry = 6'h3F; cfg_data = 1'b1; tick();
      cfg_we = 1'b0; rst = 1'b1; tick();
      check("t6_ack", cfg_ack, 1'b0);
      check("t6_valid", out_valid, 1'b0);
      check("t6_data", out_data, 2'b00);
      rst = 1'b0; cfg_req = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = (i == 0) ? 12'hFE2 : 12'($urandom); tick();
         check("t6_zero", out_data, 2'b00);
      end
      in_valid = 1'b0; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
